// File: rtl/button_event_arbiter.sv
// Button event arbiter: per-button press/long/release detection,
// round-robin serialisation of events into a valid/ready FIFO.
module button_event_arbiter #(
  parameter int unsigned NUM_BUTTONS = 4,
  parameter int unsigned LONG_TICKS  = 25000000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst_L,
  input  logic [NUM_BUTTONS-1:0]         i_Buttons,
  output logic                           o_Event_Valid,
  input  logic                           i_Event_Ready,
  output logic [$clog2(NUM_BUTTONS)-1:0] o_Event_Id,
  output logic [1:0]                     o_Event_Type,
  output logic                           o_Overflow,
  input  logic                           i_Clear_Overflow
);

  localparam int NB = NUM_BUTTONS;
  localparam int IW = $clog2(NUM_BUTTONS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = IW + 2;
  localparam logic [31:0] LT_M1 = 32'(LONG_TICKS - 1);

  localparam logic [1:0] EV_PRESS = 2'b00;
  localparam logic [1:0] EV_LONG  = 2'b01;
  localparam logic [1:0] EV_REL   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_e;

  state_e        st_q     [NB];
  state_e        st_d     [NB];
  logic [31:0]   cnt_q    [NB];
  logic [31:0]   cnt_d    [NB];
  logic [NB-1:0] prev_q;
  logic [NB-1:0] rise;
  logic [NB-1:0] fall;
  logic [NB-1:0] ev_v;
  logic [1:0]    ev_t     [NB];

  logic [NB-1:0] slot_v_q;
  logic [NB-1:0] slot_v_d;
  logic [1:0]    slot_t_q [NB];
  logic [1:0]    slot_t_d [NB];
  logic [NB-1:0] drop;

  logic [IW-1:0] rr_q;
  logic [IW-1:0] rr_d;
  logic          gnt_v;
  logic [IW-1:0] gnt_idx;
  logic [NB-1:0] gnt_oh;
  logic [IW:0]   scan;
  logic [IW-1:0] scan_idx;

  logic [EW-1:0] mem_q    [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   fcnt_q;
  logic          full;
  logic          push;
  logic          pop;
  logic          can_push;
  logic          ovf_q;
  logic          ovf_d;
  logic [EW-1:0] head;

  assign rise = ~prev_q & i_Buttons;
  assign fall = prev_q & ~i_Buttons;

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      ev_v[i]  = 1'b0;
      ev_t[i]  = EV_PRESS;
      case (st_q[i])
        ST_IDLE: begin
          if (rise[i]) begin
            st_d[i]  = ST_HELD;
            cnt_d[i] = '0;
            ev_v[i]  = 1'b1;
          end
        end
        ST_HELD: begin
          if (fall[i]) begin
            st_d[i] = ST_IDLE;
            ev_v[i] = 1'b1;
            ev_t[i] = EV_REL;
          end else if (i_Buttons[i]) begin
            if (cnt_q[i] != '1)
              cnt_d[i] = cnt_q[i] + 32'd1;
            if (cnt_q[i] == LT_M1) begin
              st_d[i] = ST_LONG;
              ev_v[i] = 1'b1;
              ev_t[i] = EV_LONG;
            end
          end
        end
        ST_LONG: begin
          if (fall[i]) begin
            st_d[i] = ST_IDLE;
            ev_v[i] = 1'b1;
            ev_t[i] = EV_REL;
          end
        end
        default: st_d[i] = ST_IDLE;
      endcase
    end
  end

  assign full     = (fcnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop      = o_Event_Valid & i_Event_Ready;
  assign can_push = ~full | pop;

  // Scan slots starting at rr_q, wrapping at NB (not necessarily 2^IW).
  always_comb begin
    gnt_v    = 1'b0;
    gnt_idx  = '0;
    gnt_oh   = '0;
    scan     = '0;
    scan_idx = '0;
    for (int k = 0; k < NB; k++) begin
      scan = {1'b0, rr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(NB))
        scan = scan - (IW+1)'(NB);
      scan_idx = scan[IW-1:0];
      if (!gnt_v && can_push && slot_v_q[scan_idx]) begin
        gnt_v   = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (gnt_v)
      gnt_oh[gnt_idx] = 1'b1;
  end

  assign push = gnt_v;
  assign rr_d = !gnt_v ? rr_q :
                (gnt_idx == IW'(NB - 1)) ? '0 : gnt_idx + IW'(1);

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      slot_v_d[i] = slot_v_q[i] & ~gnt_oh[i];
      slot_t_d[i] = slot_t_q[i];
      drop[i]     = 1'b0;
      if (ev_v[i]) begin
        if (slot_v_q[i] && !gnt_oh[i]) begin
          drop[i] = 1'b1;
        end else begin
          slot_v_d[i] = 1'b1;
          slot_t_d[i] = ev_t[i];
        end
      end
    end
  end

  assign ovf_d = (|drop) ? 1'b1 :
                 i_Clear_Overflow ? 1'b0 : ovf_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      prev_q   <= '0;
      slot_v_q <= '0;
      rr_q     <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        st_q[i]     <= ST_IDLE;
        cnt_q[i]    <= '0;
        slot_t_q[i] <= '0;
      end
      for (int j = 0; j < FIFO_DEPTH; j++)
        mem_q[j] <= '0;
    end else begin
      prev_q   <= i_Buttons;
      slot_v_q <= slot_v_d;
      rr_q     <= rr_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < NB; i++) begin
        st_q[i]     <= st_d[i];
        cnt_q[i]    <= cnt_d[i];
        slot_t_q[i] <= slot_t_d[i];
      end
      if (push) begin
        mem_q[wr_q] <= {gnt_idx, slot_t_q[gnt_idx]};
        wr_q        <= wr_q + AW'(1);
      end
      if (pop)
        rd_q <= rd_q + AW'(1);
      fcnt_q <= fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head          = mem_q[rd_q];
  assign o_Event_Valid = (fcnt_q != '0);
  assign o_Event_Id    = o_Event_Valid ? head[EW-1:2] : '0;
  assign o_Event_Type  = o_Event_Valid ? head[1:0] : 2'b00;
  assign o_Overflow    = ovf_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: directed scenarios plus random
// stimulus, checked every clock against an event-level model.
module tb_button_event_arbiter;

  localparam int NB = 4;
  localparam int LT = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn = '0;
  logic          ev_valid;
  logic          rdy = 1'b0;
  logic [1:0]    ev_id;
  logic [1:0]    ev_type;
  logic          ovf;
  logic          clr = 1'b0;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .NUM_BUTTONS(NB),
    .LONG_TICKS (LT),
    .FIFO_DEPTH (FD)
  ) dut (
    .i_Clk           (clk),
    .i_Rst_L         (rst_n),
    .i_Buttons       (btn),
    .o_Event_Valid   (ev_valid),
    .i_Event_Ready   (rdy),
    .o_Event_Id      (ev_id),
    .o_Event_Type    (ev_type),
    .o_Overflow      (ovf),
    .i_Clear_Overflow(clr)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: button history, one optional pending event per button,
  // a round-robin pointer and the FIFO as a queue of {id,type}.
  bit         m_prev [NB];
  bit         m_held [NB];
  bit         m_long [NB];
  int         m_pcyc [NB];
  bit         m_pv   [NB];
  bit   [1:0] m_pt   [NB];
  int         m_rr;
  bit         m_ovf;
  int         m_cyc;
  logic [3:0] m_q[$];

  logic [3:0] dlog[$];
  int         dcyc[$];

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_prev[i] = 0; m_held[i] = 0; m_long[i] = 0;
      m_pcyc[i] = 0; m_pv[i] = 0; m_pt[i] = 0;
    end
    m_rr = 0;
    m_ovf = 0;
    m_q.delete();
  endfunction

  task automatic model_edge(input logic [NB-1:0] b, input bit r,
                            input bit c);
    bit       p;
    bit       dr;
    int       g;
    int       ev;
    int       j;
    int       gg;
    logic [1:0] gi;
    p = (m_q.size() > 0) && r;
    g = -1;
    if (m_q.size() < FD || p)
      for (int k = 0; k < NB; k++) begin
        j = (m_rr + k) % NB;
        if (g < 0 && m_pv[j]) g = j;
      end
    if (p) void'(m_q.pop_front());
    if (g >= 0) begin
      gg = g;
      gi = gg[1:0];
      m_q.push_back({gi, m_pt[g]});
      m_pv[g] = 0;
      m_rr = (g + 1) % NB;
    end
    dr = 0;
    for (int i = 0; i < NB; i++) begin
      ev = -1;
      if (!m_prev[i] && b[i]) begin
        ev = 0;
        m_held[i] = 1; m_long[i] = 0; m_pcyc[i] = m_cyc;
      end else if (m_prev[i] && !b[i]) begin
        if (m_held[i]) ev = 2;
        m_held[i] = 0;
      end else if (m_held[i] && b[i] && !m_long[i] &&
                   (m_cyc - m_pcyc[i] == LT)) begin
        ev = 1;
        m_long[i] = 1;
      end
      m_prev[i] = b[i];
      if (ev >= 0) begin
        if (m_pv[i]) dr = 1;
        else begin
          m_pv[i] = 1;
          m_pt[i] = ev[1:0];
        end
      end
    end
    if (dr) m_ovf = 1;
    else if (c) m_ovf = 0;
    m_cyc++;
  endtask

  task automatic compare();
    logic [3:0] h;
    check("valid", ev_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      h = m_q[0];
      check("id", ev_id, h[3:2]);
      check("type", ev_type, h[1:0]);
    end
    check("ovf", ovf, m_ovf);
  endtask

  task automatic step(input logic [NB-1:0] b, input bit r, input bit c);
    btn = b;
    rdy = r;
    clr = c;
    if (ev_valid && r) begin
      dlog.push_back({ev_id, ev_type});
      dcyc.push_back(m_cyc);
    end
    @(posedge clk);
    model_edge(b, r, c);
    #1;
    compare();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", ev_valid, 0);
    check("rst_id", ev_id, 0);
    check("rst_type", ev_type, 0);
    check("rst_ovf", ovf, 0);
    #10;
    check("rst_hold_valid", ev_valid, 0);
    check("rst_hold_ovf", ovf, 0);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [NB-1:0] rb;
    m_cyc = 0;
    model_reset();
    #6;
    do_reset();

    // Short press on button 2.
    step(4'b0100, 1, 0);
    check("b2_lat1", ev_valid, 0);
    step(4'b0100, 1, 0);
    check("b2_lat2", ev_valid, 1);
    check("b2_lat2_id", ev_id, 2);
    step(4'b0100, 1, 0);
    repeat (5) step(4'b0000, 1, 0);
    check("b2_n", dlog.size(), 2);
    check("b2_e0", dlog[0], 4'b1000);
    check("b2_e1", dlog[1], 4'b1010);
    check("b2_ovf", ovf, 0);
    dlog.delete(); dcyc.delete();

    // Long hold on button 0.
    repeat (20) step(4'b0001, 1, 0);
    repeat (5) step(4'b0000, 1, 0);
    check("b0_n", dlog.size(), 3);
    check("b0_e0", dlog[0], 4'b0000);
    check("b0_e1", dlog[1], 4'b0001);
    check("b0_e2", dlog[2], 4'b0010);
    check("b0_long_dt", dcyc[1] - dcyc[0], LT);
    dlog.delete(); dcyc.delete();

    // Move rr_ptr to 2 via button 1, then press 0,1,3 together.
    step(4'b0010, 1, 0);
    repeat (5) step(4'b0000, 1, 0);
    dlog.delete(); dcyc.delete();
    repeat (3) step(4'b1011, 1, 0);
    repeat (7) step(4'b0000, 1, 0);
    check("rr_n", dlog.size(), 6);
    check("rr_e0", dlog[0], 4'b1100);
    check("rr_e1", dlog[1], 4'b0000);
    check("rr_e2", dlog[2], 4'b0100);
    check("rr_dt1", dcyc[1] - dcyc[0], 1);
    check("rr_dt2", dcyc[2] - dcyc[1], 1);
    dlog.delete(); dcyc.delete();

    // Backpressure: six events on button 1 with ready low.
    for (int i = 0; i < 6; i++)
      step((i % 2 == 0) ? 4'b0010 : 4'b0000, 0, 0);
    repeat (3) step(4'b0000, 0, 0);
    check("bp_ovf", ovf, 1);
    check("bp_head", {ev_id, ev_type}, 4'b0100);
    repeat (8) step(4'b0000, 1, 0);
    check("bp_n", dlog.size(), 5);
    for (int i = 0; i < 5; i++)
      check("bp_order", dlog[i], (i % 2 == 0) ? 4'b0100 : 4'b0110);
    step(4'b0000, 1, 1);
    check("bp_clr", ovf, 0);
    dlog.delete(); dcyc.delete();

    // Reset while button 3 is in long hold with two events queued.
    repeat (12) step(4'b1000, 0, 0);
    check("lr_queued", ev_valid, 1);
    do_reset();
    repeat (4) step(4'b1000, 1, 0);
    check("lr_n", dlog.size(), 1);
    check("lr_e0", dlog[0], 4'b1100);
    repeat (3) step(4'b0000, 1, 0);
    dlog.delete(); dcyc.delete();

    // Random traffic.
    rb = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 11) == 0) rb[i] = ~rb[i];
      step(rb, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      if (n == 1500) do_reset();
    end
    repeat (20) step('0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Turns the debounced push-button levels of the board into a single ordered stream of discrete button events: press, long-hold and release. Each button has its own hold timer and a one-deep pending slot, a round-robin arbiter serialises simultaneous events, and a small FIFO with a valid/ready handshake feeds the consumer (UI state machine, display or UART logger). The block sits directly downstream of the per-button debounce instances and is the only path from buttons into control logic.

## Interface
- NUM_BUTTONS, 4, number of button inputs, range 2..8
- LONG_TICKS, 25000000, clocks of continuous hold before a LONG event (1 s at 25 MHz), range 2..2^32-1
- FIFO_DEPTH, 4, event FIFO entries, power of two, minimum 2
- i_Clk  in  1  system clock; all logic on the rising edge
- i_Rst_L  in  1  asynchronous active-low reset
- i_Buttons  in  NUM_BUTTONS  debounced levels, 1 = pressed, synchronous to i_Clk
- o_Event_Valid  out  1  FIFO head holds an event
- i_Event_Ready  in  1  consumer accepts the head when o_Event_Valid is also 1
- o_Event_Id  out  clog2(NUM_BUTTONS)  button index of the head event
- o_Event_Type  out  2  00 PRESS, 01 LONG, 10 RELEASE; 11 never emitted
- o_Overflow  out  1  sticky: an event was dropped
- i_Clear_Overflow  in  1  synchronous clear of o_Overflow

## Operation
- Per-button registered previous level (reset 0). Rising edge = prev 0, cur 1; falling edge = prev 1, cur 0.
- Per-button FSM, states IDLE, HELD, LONG_HELD:
  - IDLE, rising edge -> HELD, hold counter = 0, raise PRESS.
  - HELD, level 1 -> counter +1; when counter == LONG_TICKS-1 -> LONG_HELD, raise LONG.
  - HELD or LONG_HELD, falling edge -> IDLE, raise RELEASE.
  - LONG_HELD: counter frozen, no further LONG until re-press.
- Hold counter: 32-bit, cleared on entry to HELD; it never wraps.
- Raised event enters that button's pending slot (valid bit + type).
- If the slot is still occupied and not granted this cycle, the new event is dropped and o_Overflow is set.
- Arbiter: at most one grant per cycle. Grant goes to the first pending button at index >= rr_ptr, wrapping to 0. Grant only when the FIFO is not full, or is full and being popped this cycle.
- On a grant: the slot is cleared, {id, type} is pushed, and rr_ptr becomes grant+1 mod NUM_BUTTONS.
- FIFO: push at tail, pop when o_Event_Valid and i_Event_Ready. o_Event_Id/o_Event_Type are the head entry and hold stable while valid and not ready.
- If the FIFO is full, pending slots wait; they do not overflow unless a further event arrives for that button.
- i_Clear_Overflow clears o_Overflow; if a drop happens in the same cycle, set wins.
- Reset (asserted any time, mid-hold or mid-handshake):
  - all FSMs IDLE, prev levels 0, counters 0, slots empty, rr_ptr 0, FIFO empty;
  - o_Event_Valid 0, o_Event_Id 0, o_Event_Type 00, o_Overflow 0.
- A button already held at reset release produces PRESS on the first clock.

## Timing
- Button edge sampled at clock k sets the pending slot at k. Grant/push at k+1 if the arbiter selects it. o_Event_Valid high after edge k+1, i.e. 2-clock minimum latency.
- LONG is raised at the clock exactly LONG_TICKS cycles after the PRESS clock.
- Simultaneous events are emitted one per clock in round-robin order.
- A slot granted at the same clock a new event is raised for that button: both kept, no overflow.
- Full FIFO with a pop and a push in the same clock: both happen, and occupancy is unchanged.

## Test plan
- Reset, then raise i_Buttons[2] for 3 clocks with ready=1 (LONG_TICKS=8):
  - Required: PRESS id 2 valid 2 clocks after the edge, then RELEASE id 2.
  - Required: no LONG event, o_Overflow=0.
- Hold button 0 for 20 clocks (LONG_TICKS=8):
  - Required: PRESS, then LONG exactly 8 clocks later, then RELEASE; exactly three events.
- Raise buttons 0, 1 and 3 on the same clock with rr_ptr=2 and ready=1:
  - Required: PRESS order id 3, 0, 1 on consecutive clocks.
- Hold ready=0 and generate 6 events on button 1 (FIFO_DEPTH=4):
  - Required: 4 in the FIFO, 1 pending, 1 dropped, o_Overflow=1.
  - Required: the head stays stable; after ready=1 the 5 surviving events drain in order.
  - Required: i_Clear_Overflow clears the flag.
- Assert i_Rst_L=0 mid-LONG_HELD with 2 events queued:
  - Required: o_Event_Valid drops immediately and all outputs return to reset values.
  - Required: a still-held button emits PRESS after reset release.
